// File: rtl/verde_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : verde_frame_sequencer
// Brief    : Splits the camera's YCbCr 4:2:2 byte stream into pixel strobes
//            for the green detector. Tracks pixel coordinates, accumulates
//            the green count and bounding box, and publishes them at frame end.
// Revision : 1.0 - initial release
// ============================================================================
module verde_frame_sequencer #(
    parameter int H_PIX     = 640,
    parameter int V_LINES   = 480,
    parameter int MIN_COUNT = 64
) (
    input  logic        PCLK,
    input  logic        reset,
    input  logic        enable,
    input  logic        VSYNC,
    input  logic        HREF,
    input  logic [7:0]  D,
    output logic        e_pix,
    output logic [7:0]  Y,
    output logic [7:0]  Cb,
    output logic [7:0]  Cr,
    input  logic        verde,
    output logic        frame_done,
    output logic [18:0] green_count,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [9:0]  y_min,
    output logic [9:0]  y_max,
    output logic        found,
    output logic        line_err
);

    localparam logic [2:0]  c_IDLE    = 3'd0;
    localparam logic [2:0]  c_WAIT    = 3'd1;
    localparam logic [2:0]  c_ACTIVE  = 3'd2;
    localparam logic [2:0]  c_DRAIN   = 3'd3;
    localparam logic [2:0]  c_PUBLISH = 3'd4;

    // Coordinates carry one extra bit so they can saturate at H_PIX / V_LINES.
    localparam logic [10:0] c_H_LIM   = 11'(H_PIX);
    localparam logic [10:0] c_V_LIM   = 11'(V_LINES);
    localparam logic [18:0] c_CNT_MAX = '1;
    localparam logic [18:0] c_MIN     = 19'(MIN_COUNT);

    logic [2:0]  r_state;
    logic        r_vs_prev;
    logic        r_href_prev;
    logic        r_drain;
    logic [1:0]  r_phase;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic [7:0]  r_cb;
    logic [7:0]  r_y0;
    logic [7:0]  r_cr;
    logic [9:0]  r_px;
    logic [9:0]  r_py;
    logic        r_strb_d;
    logic [9:0]  r_dx;
    logic [9:0]  r_dy;
    logic [18:0] r_count;
    logic [9:0]  r_xmin;
    logic [9:0]  r_xmax;
    logic [9:0]  r_ymin;
    logic [9:0]  r_ymax;

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_href_fall;
    logic w_line_end;
    logic w_pix_ok;
    logic w_frame_start;

    assign w_vs_rise     = VSYNC & ~r_vs_prev;
    assign w_vs_fall     = ~VSYNC & r_vs_prev;
    assign w_href_fall   = r_href_prev & ~HREF;
    // A frame end that arrives mid-line closes the line exactly like HREF falling.
    assign w_line_end    = w_href_fall | (w_vs_rise & HREF);
    assign w_pix_ok      = (r_x < c_H_LIM) && (r_y < c_V_LIM);
    assign w_frame_start = (r_state == c_WAIT) && w_vs_fall;

    // Previous-cycle copies of the sync inputs for edge detection.
    always_ff @(posedge PCLK) begin
        if (reset) begin
            r_vs_prev   <= 1'b0;
            r_href_prev <= 1'b0;
        end else begin
            r_vs_prev   <= VSYNC;
            r_href_prev <= HREF;
        end
    end

    // Green accumulation: delay each strobe one cycle to meet the detector flag.
    always_ff @(posedge PCLK) begin
        if (reset) begin
            r_strb_d <= 1'b0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_count  <= '0;
            r_xmin   <= '1;
            r_xmax   <= '0;
            r_ymin   <= '1;
            r_ymax   <= '0;
        end else begin
            r_strb_d <= e_pix;
            r_dx     <= r_px;
            r_dy     <= r_py;
            if (w_frame_start) begin
                r_count <= '0;
                r_xmin  <= '1;
                r_xmax  <= '0;
                r_ymin  <= '1;
                r_ymax  <= '0;
            end else if (r_strb_d && verde) begin
                if (r_count != c_CNT_MAX) r_count <= r_count + 19'd1;
                if (r_dx < r_xmin) r_xmin <= r_dx;
                if (r_dx > r_xmax) r_xmax <= r_dx;
                if (r_dy < r_ymin) r_ymin <= r_dy;
                if (r_dy > r_ymax) r_ymax <= r_dy;
            end
        end
    end

    // Frame state machine, byte demux, pixel strobe and result publication.
    always_ff @(posedge PCLK) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_drain     <= 1'b0;
            r_phase     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_cb        <= '0;
            r_y0        <= '0;
            r_cr        <= '0;
            r_px        <= '0;
            r_py        <= '0;
            e_pix       <= 1'b0;
            Y           <= '0;
            Cb          <= '0;
            Cr          <= '0;
            frame_done  <= 1'b0;
            green_count <= '0;
            x_min       <= '0;
            x_max       <= '0;
            y_min       <= '0;
            y_max       <= '0;
            found       <= 1'b0;
            line_err    <= 1'b0;
        end else begin
            e_pix      <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (enable) r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (w_vs_fall) begin
                        r_state  <= c_ACTIVE;
                        line_err <= 1'b0;
                        r_x      <= '0;
                        r_y      <= '0;
                        r_phase  <= '0;
                    end
                end
                c_ACTIVE: begin
                    if (w_line_end) begin
                        r_x     <= '0;
                        r_phase <= '0;
                        if (r_y < c_V_LIM) r_y <= r_y + 11'd1;
                        if (r_phase != 2'd0) line_err <= 1'b1;
                    end else if (HREF) begin
                        r_phase <= r_phase + 2'd1;
                        case (r_phase)
                            2'd0: r_cb <= D;
                            2'd1: r_y0 <= D;
                            2'd2: begin
                                r_cr <= D;
                                if (w_pix_ok) begin
                                    e_pix <= 1'b1;
                                    Y     <= r_y0;
                                    Cb    <= r_cb;
                                    Cr    <= D;
                                    r_px  <= r_x[9:0];
                                    r_py  <= r_y[9:0];
                                end
                                if (r_x < c_H_LIM) r_x <= r_x + 11'd1;
                            end
                            default: begin
                                if (w_pix_ok) begin
                                    e_pix <= 1'b1;
                                    Y     <= D;
                                    Cb    <= r_cb;
                                    Cr    <= r_cr;
                                    r_px  <= r_x[9:0];
                                    r_py  <= r_y[9:0];
                                end
                                if (r_x < c_H_LIM) r_x <= r_x + 11'd1;
                            end
                        endcase
                    end
                    if (w_vs_rise) begin
                        r_state <= c_DRAIN;
                        r_drain <= 1'b0;
                    end
                end
                c_DRAIN: begin
                    // Two cycles let the last pixel's flag land in the count.
                    if (r_drain) begin
                        r_state     <= c_PUBLISH;
                        frame_done  <= 1'b1;
                        green_count <= r_count;
                        found       <= (r_count >= c_MIN);
                        if (r_count == '0) begin
                            x_min <= '0;
                            x_max <= '0;
                            y_min <= '0;
                            y_max <= '0;
                        end else begin
                            x_min <= r_xmin;
                            x_max <= r_xmax;
                            y_min <= r_ymin;
                            y_max <= r_ymax;
                        end
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                c_PUBLISH: begin
                    r_state <= enable ? c_WAIT : c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
